// File: rtl/operation_pkg.sv
// Shared types for the ALU control path: the operation encoding seen by the
// datapath and the sequencer state encoding.
package operation_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_INC   = 4'd8,
    OP_DEC   = 4'd9,
    OP_PASSA = 4'd10,
    OP_PASSB = 4'd11,
    OP_CMP   = 4'd12,
    OP_MUL   = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } Operation;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IN   = 3'd1,
    S_ALU  = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/ctrl_sequencer_sat_counter.sv
// Increment-only counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Command-driven controller that steps the datain/aluin/aluout register enables,
// optionally stretches execute for multi-cycle ops, and hands the result off.
module ctrl_sequencer
  import operation_pkg::*;
#(
  parameter int               SEL_W     = 2,
  parameter int               OP_W      = 2,
  parameter logic [SEL_W-1:0] EXT_SEL   = '1,
  parameter logic [15:0]      MC_OPS    = 16'h0000,
  parameter int               MC_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*SEL_W+OP_W-1:0]   cmd_in,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      p_error,
  output logic                      datain_reg_en,
  output logic                      aluin_reg_en,
  output logic                      aluout_reg_en,
  output logic [SEL_W-1:0]          in_select_a,
  output logic [SEL_W-1:0]          in_select_b,
  output Operation                  opcode,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      nvalid_data,
  output logic [7:0]                err_count
);

  localparam int CMD_W = 2*SEL_W + OP_W;
  localparam int CNT_W = $clog2(MC_CYCLES) + 1;
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(MC_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  generate
    if (OP_W < 1 || OP_W > 4) begin : g_bad_op_w
      $error("ctrl_sequencer: OP_W must be in 1..4");
    end
    if (MC_CYCLES < 2) begin : g_bad_mc_cycles
      $error("ctrl_sequencer: MC_CYCLES must be at least 2");
    end
  endgenerate

  ctrl_state_e      state;
  logic [CMD_W-1:0] cmd_q;
  logic [CNT_W-1:0] exec_cnt;

  logic [SEL_W-1:0] q_sel_a;
  logic [SEL_W-1:0] q_sel_b;
  logic [OP_W-1:0]  q_op;
  logic [3:0]       op_ext;
  logic             is_mc;
  logic             uses_ext;
  logic             err_inc;

  assign q_sel_a  = cmd_q[CMD_W-1 -: SEL_W];
  assign q_sel_b  = cmd_q[OP_W+SEL_W-1 -: SEL_W];
  assign q_op     = cmd_q[OP_W-1:0];
  assign op_ext   = 4'(q_op);
  assign is_mc    = MC_OPS[op_ext];
  assign uses_ext = (q_sel_a == EXT_SEL) || (q_sel_b == EXT_SEL);

  // Selects and opcode come straight from the command register, so they
  // change only on accept and are cleared by reset along with it.
  assign in_select_a = q_sel_a;
  assign in_select_b = q_sel_b;
  assign opcode      = Operation'(op_ext);
  assign cmd_ready   = (state == S_IDLE);

  // Each enable is raised on the edge that enters its state, so the datapath
  // sees it on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_q         <= '0;
      exec_cnt      <= '0;
      datain_reg_en <= 1'b0;
      aluin_reg_en  <= 1'b0;
      aluout_reg_en <= 1'b0;
      res_valid     <= 1'b0;
      nvalid_data   <= 1'b0;
    end else begin
      datain_reg_en <= 1'b0;
      aluin_reg_en  <= 1'b0;
      aluout_reg_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q         <= cmd_in;
            nvalid_data   <= 1'b0;
            datain_reg_en <= 1'b1;
            state         <= S_IN;
          end
        end
        S_IN: begin
          nvalid_data  <= p_error && uses_ext;
          aluin_reg_en <= 1'b1;
          state        <= S_ALU;
        end
        S_ALU: begin
          if (is_mc) begin
            exec_cnt <= EXEC_LOAD;
            state    <= S_EXEC;
          end else begin
            aluout_reg_en <= 1'b1;
            state         <= S_OUT;
          end
        end
        S_EXEC: begin
          if (exec_cnt == '0) begin
            aluout_reg_en <= 1'b1;
            state         <= S_OUT;
          end else begin
            exec_cnt <= exec_cnt - CNT_ONE;
          end
        end
        S_OUT: begin
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign err_inc = (state == S_DONE) && res_ready && nvalid_data;

  sat_counter #(
    .W(8)
  ) u_err_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_inc),
    .count(err_count)
  );

endmodule
